commit_trace_buffer: RTL

- Synthesizable commit-trace recorder next to the single-cycle CPU core.
- Logs one record per retired instruction into a circular buffer:
  - retirement is detected as a PC change, as the simulation bench does;
  - each record holds the PC, the instruction and that cycle's register-file write.
- Three capture modes: wrap, fill-and-stop, PC-triggered with post-trigger count.
- Records drain through a first-word-fall-through ready/valid port to a UART/debug bridge.

---
 rtl/cpu54_dbg_pkg.sv | 40 ++++
 rtl/commit_trace_buffer_if.sv | 25 ++
 rtl/commit_trace_buffer_ram.sv | 34 +++
 rtl/commit_trace_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu54_dbg_pkg.sv
// Shared definitions for the CPU debug/trace blocks: capture modes, trace FSM
// states and the commit record layout.
package cpu54_dbg_pkg;

    localparam int DBG_PC_W   = 32;
    localparam int DBG_INST_W = 32;
    localparam int DBG_DATA_W = 32;
    localparam int DBG_REG_AW = 5;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_FILL = 2'd1,
        MODE_TRIG = 2'd2
    } trace_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [DBG_PC_W-1:0]   pc;
        logic [DBG_INST_W-1:0] inst;
        logic                  wb_en;
        logic [DBG_REG_AW-1:0] wb_addr;
        logic [DBG_DATA_W-1:0] wb_data;
    } trace_rec_t;

    // The reserved encoding 3 behaves as a plain circular log.
    function automatic trace_mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_FILL;
            2'd2:    return MODE_TRIG;
            default: return MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// First-word-fall-through drain port of the commit trace buffer.
interface commit_trace_buffer_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              rd_valid;
    logic              rd_ready;
    logic [PC_W-1:0]   rd_pc;
    logic [INST_W-1:0] rd_inst;
    logic              rd_wb_en;
    logic [REG_AW-1:0] rd_wb_addr;
    logic [DATA_W-1:0] rd_wb_data;

    modport master (
        output rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_addr, rd_wb_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid, rd_pc, rd_inst, rd_wb_en, rd_wb_addr, rd_wb_data,
        output rd_ready
    );
endinterface

// File: rtl/commit_trace_buffer_ram.sv
// Register-array storage for trace records: one synchronous write port and an
// asynchronous read port; contents cleared by reset.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace recorder: logs one record per PC change into a circular buffer
// with wrap, fill-and-stop and PC-triggered capture, drained over an FWFT port.
module commit_trace_buffer
    import cpu54_dbg_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clear,
    input  logic [1:0]        mode,
    input  logic [PC_W-1:0]   trig_pc,
    input  logic [CNT_W-1:0]  post_cnt,
    input  logic [PC_W-1:0]   pc,
    input  logic [INST_W-1:0] inst,
    input  logic              rf_we,
    input  logic [REG_AW-1:0] rf_waddr,
    input  logic [DATA_W-1:0] rf_wdata,
    commit_trace_buffer_if.master rd,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              triggered,
    output logic              done
);
    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = PC_W + INST_W + 1 + REG_AW + DATA_W;

    trace_state_e     state_q, state_d;
    trace_mode_e      mode_q, mode_d;
    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] post_q, post_d;
    logic [PC_W-1:0]  pc_prev_q, pc_prev_d;
    logic             first_q, first_d;
    logic             overflow_q, overflow_d;
    logic             triggered_q, triggered_d;

    logic             running;
    logic             full;
    logic             pop;
    logic             capture;
    logic             push;
    logic             overwrite;
    logic             ram_we;
    logic [REC_W-1:0] ram_wdata;
    logic [REC_W-1:0] ram_rdata;

    assign ram_wdata = {pc, inst, rf_we && (rf_waddr != '0), rf_waddr, rf_wdata};

    // Next-state, pointer and flag logic; clear overrides everything but reset,
    // and a full FILL buffer refuses new records instead of overwriting.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        post_d      = post_q;
        pc_prev_d   = pc_prev_q;
        first_d     = first_q;
        overflow_d  = overflow_q;
        triggered_d = triggered_q;
        ram_we      = 1'b0;

        running   = (state_q == ST_RUN) || (state_q == ST_POST);
        full      = (count_q == CNT_W'(DEPTH));
        pop       = (count_q != '0) && rd.rd_ready;
        capture   = running && en && ((pc != pc_prev_q) || first_q);
        push      = capture && !((mode_q == MODE_FILL) && full);
        overwrite = push && full && !pop;

        if (running) begin
            pc_prev_d = pc;
        end

        if (clear) begin
            state_d     = ST_IDLE;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            first_d     = 1'b1;
            overflow_d  = 1'b0;
            triggered_d = 1'b0;
        end else begin
            ram_we = push;
            if (pop || overwrite) begin
                head_d = head_q + AW'(1);
            end
            if (push) begin
                tail_d  = tail_q + AW'(1);
                first_d = 1'b0;
            end
            if (push && !pop && !full) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
            if (overwrite) begin
                overflow_d = 1'b1;
            end

            if (!en) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d = ST_RUN;
                        mode_d  = norm_mode(mode);
                        post_d  = (post_cnt > CNT_W'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : post_cnt;
                    end
                    ST_RUN: begin
                        if (push && (mode_q == MODE_FILL) && (count_q == CNT_W'(DEPTH - 1)) && !pop) begin
                            state_d = ST_DONE;
                        end else if (push && (mode_q == MODE_TRIG) && (pc == trig_pc)) begin
                            triggered_d = 1'b1;
                            state_d     = (post_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                    ST_POST: begin
                        if (push) begin
                            post_d = post_q - CNT_W'(1);
                            if (post_q == CNT_W'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_WRAP;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            post_q      <= '0;
            pc_prev_q   <= '0;
            first_q     <= 1'b1;
            overflow_q  <= 1'b0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            post_q      <= post_d;
            pc_prev_q   <= pc_prev_d;
            first_q     <= first_d;
            overflow_q  <= overflow_d;
            triggered_q <= triggered_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (tail_q),
        .wdata (ram_wdata),
        .raddr (head_q),
        .rdata (ram_rdata)
    );

    assign {rd.rd_pc, rd.rd_inst, rd.rd_wb_en, rd.rd_wb_addr, rd.rd_wb_data} = ram_rdata;
    assign rd.rd_valid = (count_q != '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign triggered   = triggered_q;
    assign done        = (state_q == ST_DONE);
endmodule
